pipe_reg_chain: RTL and testbench



---
 rtl/pipe_reg_chain.sv | 110 +++++++++++
 tb/tb_pipe_reg_chain.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_chain.sv
// Multi-stage pipeline register chain with per-stage hold, flush (bubble insert) and valid tracking.
// Optional stall/bubble statistics counters are enabled by defining PIPE_REG_CHAIN_STATS_EN.
module pipe_reg_chain #(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      DEPTH        = 4,
  parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  input  logic [DEPTH-1:0]       hold,
  input  logic [DEPTH-1:0]       flush,
  output logic                   in_ready,
  output logic [DEPTH*WIDTH-1:0] stage_data,
  output logic [DEPTH-1:0]       stage_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  output logic [31:0]            bubble_cnt,
  output logic [31:0]            hold_cnt
);

  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d, prev_data;
  logic [DEPTH-1:0]            valid_q, valid_d, prev_valid;
  logic [DEPTH-1:0]            eh;

  // A stage is effectively held if it or any downstream stage is held. Flush is
  // deliberately excluded so a bubble never releases the stall behind it.
  always_comb begin
    eh = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      eh[i] = |(hold >> i);
    end
  end

  always_comb begin
    prev_data     = '0;
    prev_valid    = '0;
    prev_data[0]  = in_data;
    prev_valid[0] = in_valid;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      prev_data[i]  = data_q[i-1];
      prev_valid[i] = valid_q[i-1];
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (flush[i]) begin
        data_d[i]  = BUBBLE_VALUE;
        valid_d[i] = 1'b0;
      end else if (!eh[i]) begin
        data_d[i]  = prev_data[i];
        valid_d[i] = prev_valid[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= {DEPTH{BUBBLE_VALUE}};
      valid_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign in_ready    = ~eh[0];
  assign stage_data  = data_q;
  assign stage_valid = valid_q;
  assign out_data    = data_q[DEPTH-1];
  assign out_valid   = valid_q[DEPTH-1];

`ifdef PIPE_REG_CHAIN_STATS_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;

  // Both counters saturate rather than wrap.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    if (!eh[DEPTH-1] && !valid_q[DEPTH-1] && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
    if (eh[0] && (hold_cnt_q != 32'hFFFF_FFFF)) begin
      hold_cnt_d = hold_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= '0;
      hold_cnt_q   <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign hold_cnt   = hold_cnt_q;
`else
  assign bubble_cnt = '0;
  assign hold_cnt   = '0;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed self-checking bench for pipe_reg_chain (WIDTH=32, DEPTH=4), covering reset, streaming,
// load-use stall, downstream hold, flush-over-hold and statistics counters.
module tb_pipe_reg_chain;

  localparam int unsigned Width = 32;
  localparam int unsigned Depth = 4;
`ifdef PIPE_REG_CHAIN_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic                   clk;
  logic                   rst;
  logic [Width-1:0]       in_data;
  logic                   in_valid;
  logic [Depth-1:0]       hold;
  logic [Depth-1:0]       flush;
  logic                   in_ready;
  logic [Depth*Width-1:0] stage_data;
  logic [Depth-1:0]       stage_valid;
  logic [Width-1:0]       out_data;
  logic                   out_valid;
  logic [31:0]            bubble_cnt;
  logic [31:0]            hold_cnt;

  int n_checks;
  int n_fail;

  pipe_reg_chain #(
    .WIDTH       (Width),
    .DEPTH       (Depth),
    .BUBBLE_VALUE('0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .hold       (hold),
    .flush      (flush),
    .in_ready   (in_ready),
    .stage_data (stage_data),
    .stage_valid(stage_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .bubble_cnt (bubble_cnt),
    .hold_cnt   (hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] stg(input int i);
    return stage_data[i*Width +: Width];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stages(input string tag, input logic [31:0] s0, input logic [31:0] s1,
                              input logic [31:0] s2, input logic [31:0] s3,
                              input logic [3:0] v);
    check_eq({tag, ".s0"}, stg(0), s0);
    check_eq({tag, ".s1"}, stg(1), s1);
    check_eq({tag, ".s2"}, stg(2), s2);
    check_eq({tag, ".s3"}, stg(3), s3);
    check_eq({tag, ".valid"}, {28'd0, stage_valid}, {28'd0, v});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    in_data  = 32'hAA;
    in_valid = 1'b1;
    hold     = '0;
    flush    = '0;

    // T1 reset
    tick();
    tick();
    check_stages("reset", 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000);
    check_eq("reset.bubble_cnt", bubble_cnt, 32'd0);
    check_eq("reset.hold_cnt", hold_cnt, 32'd0);
    check_eq("reset.in_ready", {31'd0, in_ready}, 32'd1);
    rst     = 1'b0;
    in_data = 32'h11;
    tick();  // E1
    check_stages("first_load", 32'h11, 32'h0, 32'h0, 32'h0, 4'b0001);

    // T2 streaming
    in_data = 32'h22; tick();  // E2
    in_data = 32'h33; tick();  // E3
    in_data = 32'h44; tick();  // E4
    check_eq("stream.out_data0", out_data, 32'h11);
    check_eq("stream.out_valid0", {31'd0, out_valid}, 32'd1);
    check_stages("stream", 32'h44, 32'h33, 32'h22, 32'h11, 4'b1111);
    in_data = 32'h55; tick();  // E5
    check_eq("stream.out_data1", out_data, 32'h22);

    // T3 load-use: stage1=0x44, stage0=0x55
    hold    = 4'b0001;
    flush   = 4'b0010;
    in_data = 32'h66;
    #1;
    check_eq("loaduse.in_ready", {31'd0, in_ready}, 32'd0);
    tick();  // E6
    check_stages("loaduse", 32'h55, 32'h0, 32'h44, 32'h33, 4'b1101);
    hold  = '0;
    flush = '0;
    #1;
    check_eq("loaduse.in_ready_rel", {31'd0, in_ready}, 32'd1);
    tick();  // E7
    check_stages("loaduse_next", 32'h66, 32'h55, 32'h0, 32'h44, 4'b1011);

    // T4 downstream hold for three cycles
    hold    = 4'b1000;
    in_data = 32'h77;
    #1;
    check_eq("dhold.in_ready", {31'd0, in_ready}, 32'd0);
    tick();  // E8
    tick();  // E9
    tick();  // E10
    check_stages("dhold", 32'h66, 32'h55, 32'h0, 32'h44, 4'b1011);
    check_eq("dhold.hold_cnt", hold_cnt, StatsEn ? 32'd4 : 32'd0);
    hold = '0;
    tick();  // E11
    check_stages("dhold_rel", 32'h77, 32'h66, 32'h55, 32'h0, 4'b0111);
    in_data = 32'h88;
    tick();  // E12
    check_stages("dhold_rel2", 32'h88, 32'h77, 32'h66, 32'h55, 4'b1111);

    // T6 stats: four bubbles exited during fill, one more at E12
    check_eq("stats.bubble_cnt", bubble_cnt, StatsEn ? 32'd5 : 32'd0);
    check_eq("stats.hold_cnt", hold_cnt, StatsEn ? 32'd4 : 32'd0);

    // T5 flush overrides hold on the same stage
    hold    = 4'b0100;
    flush   = 4'b0100;
    in_data = 32'h99;
    #1;
    check_eq("flushhold.in_ready", {31'd0, in_ready}, 32'd0);
    tick();  // E13
    check_stages("flushhold", 32'h88, 32'h77, 32'h0, 32'h66, 4'b1011);
    check_eq("flushhold.hold_cnt", hold_cnt, StatsEn ? 32'd5 : 32'd0);
    hold  = '0;
    flush = '0;

    // T6 reset mid-stream
    rst = 1'b1;
    tick();  // E14
    check_stages("midrst", 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000);
    check_eq("midrst.bubble_cnt", bubble_cnt, 32'd0);
    check_eq("midrst.hold_cnt", hold_cnt, 32'd0);
    rst = 1'b0;
    tick();  // E15
    check_stages("postrst", 32'h99, 32'h0, 32'h0, 32'h0, 4'b0001);
    check_eq("postrst.bubble_cnt", bubble_cnt, StatsEn ? 32'd1 : 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
